// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings, opcode and the
// multiply/divide unit state and operation-kind encodings.
package rv32_pkg;

  localparam logic [6:0] OPC_OP = 7'b0110011;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // Which slice of the shared accumulator is returned at the end.
  typedef enum logic [1:0] {
    MDU_MUL_LO = 2'd0,
    MDU_MUL_HI = 2'd1,
    MDU_DIV    = 2'd2,
    MDU_REM    = 2'd3
  } mdu_kind_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add
// multiply and restoring divide sharing one 2*XLEN accumulator.
module ex_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            mdu_stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned W2    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  mdu_state_e      state, state_nxt;
  mdu_kind_e       kind, kind_dec;
  logic [CNT_W-1:0] counter;
  logic [W2-1:0]   acc, acc_step;
  logic [XLEN-1:0] b_reg;
  logic            neg;

  logic            accept, a_signed, b_signed, sign_dec;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, rem_sh, div_diff;
  logic [W2-1:0]   prod_fin;
  logic [XLEN-1:0] quo_fin, rem_fin, res_fin;

  // Operand decode at accept time: magnitudes, sign flag, special cases.
  always_comb begin
    a_signed = (funct3 == MULH) || (funct3 == MULHSU) || (funct3 == DIV) || (funct3 == REM);
    b_signed = (funct3 == MULH) || (funct3 == DIV) || (funct3 == REM);
    a_mag    = (a_signed && rs1_data[XLEN-1]) ? (~rs1_data) + XLEN'(1) : rs1_data;
    b_mag    = (b_signed && rs2_data[XLEN-1]) ? (~rs2_data) + XLEN'(1) : rs2_data;

    if (funct3 == MUL)        kind_dec = MDU_MUL_LO;
    else if (!funct3[2])      kind_dec = MDU_MUL_HI;
    else if (!funct3[1])      kind_dec = MDU_DIV;
    else                      kind_dec = MDU_REM;

    if (kind_dec == MDU_REM)  sign_dec = a_signed && rs1_data[XLEN-1];
    else                      sign_dec = (a_signed && rs1_data[XLEN-1]) ^ (b_signed && rs2_data[XLEN-1]);

    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
  end

  // One multiply or divide iteration on the shared accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:XLEN]} + {1'b0, b_reg};
    rem_sh   = acc[W2-1:XLEN-1];
    div_diff = rem_sh - {1'b0, b_reg};
    if (kind == MDU_MUL_LO || kind == MDU_MUL_HI) begin
      acc_step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[W2-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result selection for the DONE state.
  always_comb begin
    prod_fin = neg ? (~acc) + W2'(1) : acc;
    quo_fin  = neg ? (~acc[XLEN-1:0]) + XLEN'(1) : acc[XLEN-1:0];
    rem_fin  = neg ? (~acc[W2-1:XLEN]) + XLEN'(1) : acc[W2-1:XLEN];
    case (kind)
      MDU_MUL_LO: res_fin = prod_fin[XLEN-1:0];
      MDU_MUL_HI: res_fin = prod_fin[W2-1:XLEN];
      MDU_DIV:    res_fin = quo_fin;
      default:    res_fin = rem_fin;
    endcase
  end

  // Next state and pipeline stall.
  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    mdu_stall = accept || (state == CALC);
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (div_zero || div_ovf) ? DONE : CALC;
        CALC:    if (counter == LAST_IT) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      kind    <= MDU_MUL_LO;
      counter <= '0;
      acc     <= '0;
      b_reg   <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (flush) begin
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              kind    <= kind_dec;
              b_reg   <= b_mag;
              counter <= '0;
              // Special divides preload the final {remainder, quotient} unsigned.
              if (div_zero) begin
                acc <= {rs1_data, ALL_ONES};
                neg <= 1'b0;
              end else if (div_ovf) begin
                acc <= {{XLEN{1'b0}}, MIN_NEG};
                neg <= 1'b0;
              end else begin
                acc <= {{XLEN{1'b0}}, a_mag};
                neg <= sign_dec;
              end
            end
          end
          CALC: begin
            acc     <= acc_step;
            counter <= (counter == LAST_IT) ? '0 : counter + CNT_W'(1);
          end
          DONE: begin
            result <= res_fin;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: table of M ops with
// expected result, latency and stall count, plus flush/reset sequences.
module tb_ex_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, result;
  logic        mdu_stall, done;

  int n_vec = 0;
  int n_err = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mdu_stall(mdu_stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
    int          exp_stall;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op; return result, clocks from accept edge to done, and stalled cycles.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
    @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b; start = 1'b1;
    #1 stalls = mdu_stall ? 1 : 0;
    @(posedge clk);
    #1 start = 1'b0;
    if (mdu_stall) stalls++;
    lat = 0;
    res = 32'hDEAD_BEEF;
    while (lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (done) begin
        res = result;
        break;
      end
      if (mdu_stall) stalls++;
    end
  endtask

  initial begin
    logic [31:0] res, last_exp;
    int lat, stalls, done_seen;

    vecs[0]  = '{F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 33};
    vecs[1]  = '{F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 33};
    vecs[2]  = '{F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33};
    vecs[3]  = '{F_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 33};
    vecs[4]  = '{F_MULHU,  32'h8000_0000,  32'd2,         32'h0000_0001, 33, 33};
    vecs[5]  = '{F_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33, 33};
    vecs[6]  = '{F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 33};
    vecs[7]  = '{F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 33};
    vecs[8]  = '{F_DIVU,   32'd100,        32'd7,         32'd14,        33, 33};
    vecs[9]  = '{F_REMU,   32'd100,        32'd7,         32'd2,         33, 33};
    vecs[10] = '{F_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 33};
    vecs[11] = '{F_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33, 33};
    vecs[12] = '{F_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, 33};
    vecs[13] = '{F_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  1};
    vecs[14] = '{F_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1,  1};
    vecs[15] = '{F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  1};
    vecs[16] = '{F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall", 32'(mdu_stall), 32'd0);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, stalls);
      check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_stall_cycles", i), 32'(stalls), 32'(vecs[i].exp_stall));
      if (i == 0) begin
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
      end
    end
    last_exp = vecs[16].exp_res;

    // Flush at CALC cycle 10 of a DIVU: no done, result untouched, back in IDLE.
    @(negedge clk);
    funct3 = F_DIVU; rs1_data = 32'd1000; rs2_data = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_stall", 32'(mdu_stall), 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("flush_no_done", 32'(done_seen), 32'd0);
    check("flush_result_kept", result, last_exp);
    run_op(F_DIVU, 32'd1000, 32'd3, res, lat, stalls);
    check("post_flush_result", res, 32'd333);
    check("post_flush_latency", 32'(lat), 32'd33);

    // Reset in the middle of CALC.
    @(negedge clk);
    funct3 = F_MUL; rs1_data = 32'd9; rs2_data = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", 32'(mdu_stall), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Start together with flush is never accepted.
    @(negedge clk);
    funct3 = F_MUL; rs1_data = 32'd3; rs2_data = 32'd4; start = 1'b1; flush = 1'b1;
    #1 check("start_flush_stall", 32'(mdu_stall), 32'd0);
    @(posedge clk); #1;
    check("start_flush_stall_after", 32'(mdu_stall), 32'd0);
    start = 1'b0; flush = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("start_flush_no_done", 32'(done_seen), 32'd0);
    check("start_flush_result", result, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
